// File: rtl/fifo_prog_if.sv
// Handshake/status bundle for fifo_prog.
// The master side drives requests and thresholds. The slave side (the FIFO) returns data and flags.
interface fifo_prog_if #(
  parameter int data_width    = 6,
  parameter int address_width = 2
);
  logic                   wr_enable;
  logic                   rd_enable;
  logic [data_width-1:0]  data_in;
  logic [address_width:0] umbral_alto;
  logic [address_width:0] umbral_bajo;
  logic                   err_clear;
  logic [data_width-1:0]  data_out;
  logic                   valid_out;
  logic [address_width:0] fifo_count;
  logic                   full_fifo;
  logic                   empty_fifo;
  logic                   almost_full_fifo;
  logic                   almost_empty_fifo;
  logic                   overflow;
  logic                   underflow;
  logic                   error;

  modport master (
    output wr_enable, rd_enable, data_in, umbral_alto, umbral_bajo, err_clear,
    input  data_out, valid_out, fifo_count, full_fifo, empty_fifo,
           almost_full_fifo, almost_empty_fifo, overflow, underflow, error
  );

  modport slave (
    input  wr_enable, rd_enable, data_in, umbral_alto, umbral_bajo, err_clear,
    output data_out, valid_out, fifo_count, full_fifo, empty_fifo,
           almost_full_fifo, almost_empty_fifo, overflow, underflow, error
  );
endinterface

// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds.
// It has an occupancy count, an optional first-word-fall-through read and sticky overflow/underflow flags.
module fifo_prog #(
  parameter int data_width    = 6,
  parameter int address_width = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  fifo_prog_if.slave bus
);
  localparam int DEPTH = 2 ** address_width;
  localparam logic [address_width:0] DEPTH_CNT = {1'b1, {address_width{1'b0}}};

  logic [data_width-1:0]    mem_q [DEPTH];
  logic [data_width-1:0]    mem_d [DEPTH];
  logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [address_width:0]   count_q, count_d;
  logic [data_width-1:0]    dout_q, dout_d;
  logic                     vld_q, vld_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     full, empty, rd_acc, wr_acc, ovf_evt, udf_evt;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign rd_acc  = bus.rd_enable & ~empty;
  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign wr_acc  = bus.wr_enable & (~full | rd_acc);
  assign ovf_evt = bus.wr_enable & full & ~bus.rd_enable;
  assign udf_evt = bus.rd_enable & empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    if (wr_acc) begin
      mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (!FWFT) begin
        dout_d = mem_q[rd_ptr_q];
        vld_d  = 1'b1;
      end
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A fresh event in the clearing cycle keeps the flag set.
    ovf_d = ovf_evt | (ovf_q & ~bus.err_clear);
    udf_d = udf_evt | (udf_q & ~bus.err_clear);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.data_out          = FWFT ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
  assign bus.valid_out         = FWFT ? ~empty : vld_q;
  assign bus.fifo_count        = count_q;
  assign bus.full_fifo         = full;
  assign bus.empty_fifo        = empty;
  assign bus.almost_full_fifo  = (count_q >= bus.umbral_alto);
  assign bus.almost_empty_fifo = (count_q <= bus.umbral_bajo);
  assign bus.overflow          = ovf_q;
  assign bus.underflow         = udf_q;
  assign bus.error             = ovf_q | udf_q;
endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: a registered-read and a fall-through instance share one stimulus stream.
// Both are checked every cycle against a queue-based model of the FIFO rules.
module tb_fifo_prog;
  localparam int DW = 6, AW = 2, DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_prog_if #(.data_width(DW), .address_width(AW)) b0 ();
  fifo_prog_if #(.data_width(DW), .address_width(AW)) b1 ();

  fifo_prog #(.data_width(DW), .address_width(AW), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset(reset), .bus(b0));
  fifo_prog #(.data_width(DW), .address_width(AW), .FWFT(1'b1)) u_ft (
    .clk(clk), .reset(reset), .bus(b1));

  int checks = 0, failures = 0;

  logic          i_wr, i_rd, i_clr;
  logic [DW-1:0] i_din;
  logic [AW:0]   th_hi, th_lo;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_vld;
  logic [DW-1:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic wr, input logic rd, input logic [DW-1:0] din,
                        input logic clr, input logic rst_n);
    i_wr = wr; i_rd = rd; i_din = din; i_clr = clr; reset = rst_n;
    b0.wr_enable = wr; b0.rd_enable = rd; b0.data_in = din; b0.err_clear = clr;
    b1.wr_enable = wr; b1.rd_enable = rd; b1.data_in = din; b1.err_clear = clr;
    b0.umbral_alto = th_hi; b0.umbral_bajo = th_lo;
    b1.umbral_alto = th_hi; b1.umbral_bajo = th_lo;
  endtask

  // Reference behaviour at a clock edge, from the pre-edge queue and inputs.
  task automatic model_edge();
    bit ovf_ev, udf_ev, rd_ok, wr_ok;
    if (!reset) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0; m_dout = '0;
      return;
    end
    rd_ok  = i_rd && q.size() > 0;
    wr_ok  = i_wr && (q.size() < DEPTH || rd_ok);
    ovf_ev = i_wr && q.size() == DEPTH && !i_rd;
    udf_ev = i_rd && q.size() == 0;
    m_vld  = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(i_din);
    m_ovf = ovf_ev || (m_ovf && !i_clr);
    m_udf = udf_ev || (m_udf && !i_clr);
  endtask

  task automatic chk_status(input string ph, input logic [AW:0] cnt, input logic f, input logic e,
                            input logic af, input logic ae, input logic ov, input logic un,
                            input logic er);
    int n = q.size();
    chk({ph, ".count"}, 32'(cnt), 32'(n));
    chk({ph, ".full"},  32'(f),   32'(n == DEPTH));
    chk({ph, ".empty"}, 32'(e),   32'(n == 0));
    chk({ph, ".afull"}, 32'(af),  32'(n >= int'(th_hi)));
    chk({ph, ".aempty"},32'(ae),  32'(n <= int'(th_lo)));
    chk({ph, ".ovf"},   32'(ov),  32'(m_ovf));
    chk({ph, ".udf"},   32'(un),  32'(m_udf));
    chk({ph, ".error"}, 32'(er),  32'(m_ovf || m_udf));
  endtask

  task automatic check_all(input string ph);
    chk_status({ph, ".r"}, b0.fifo_count, b0.full_fifo, b0.empty_fifo, b0.almost_full_fifo,
               b0.almost_empty_fifo, b0.overflow, b0.underflow, b0.error);
    chk_status({ph, ".f"}, b1.fifo_count, b1.full_fifo, b1.empty_fifo, b1.almost_full_fifo,
               b1.almost_empty_fifo, b1.overflow, b1.underflow, b1.error);
    chk({ph, ".r.valid"}, 32'(b0.valid_out), 32'(m_vld));
    chk({ph, ".r.data"},  32'(b0.data_out),  32'(m_dout));
    chk({ph, ".f.valid"}, 32'(b1.valid_out), 32'(q.size() > 0));
    chk({ph, ".f.data"},  32'(b1.data_out),  32'(q.size() > 0 ? q[0] : '0));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [DW-1:0] popped[$];
    int exp_seq[6] = '{1, 2, 3, 4, 10, 11};

    th_hi = 3'd3; th_lo = 3'd1;
    set_in(0, 0, '0, 0, 0);
    m_ovf = 0; m_udf = 0; m_vld = 0; m_dout = '0;

    // 1: reset values
    repeat (3) step("t1");
    chk("t1.count", 32'(b0.fifo_count), 0);
    chk("t1.empty", 32'(b0.empty_fifo), 1);
    chk("t1.aempty", 32'(b0.almost_empty_fifo), 1);
    chk("t1.data", 32'(b0.data_out), 0);
    set_in(0, 0, '0, 0, 1);

    // 2: fill and overflow
    for (int v = 1; v <= 5; v++) begin
      set_in(1, 0, DW'(v), 0, 1);
      step("t2");
      if (v == 3) chk("t2.afull", 32'(b0.almost_full_fifo), 1);
      if (v == 4) begin
        chk("t2.full", 32'(b0.full_fifo), 1);
        chk("t2.count", 32'(b0.fifo_count), 4);
        chk("t2.ovf_pre", 32'(b0.overflow), 0);
      end
      if (v == 5) chk("t2.ovf", 32'(b0.overflow), 1);
    end

    // 3: drain in order, then underflow and clear
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, '0, 0, 1);
      step("t3");
      if (i < 4) begin
        chk("t3.data", 32'(b0.data_out), 32'(i + 1));
        chk("t3.valid", 32'(b0.valid_out), 1);
      end
      if (i == 3) chk("t3.empty", 32'(b0.empty_fifo), 1);
      if (i == 4) chk("t3.udf", 32'(b0.underflow), 1);
    end
    chk("t3.error", 32'(b0.error), 1);
    set_in(0, 0, '0, 1, 1);
    step("t3c");
    chk("t3.error_clr", 32'(b0.error), 0);

    // 4: full-rate read/write across the pointer wrap
    for (int v = 1; v <= 4; v++) begin
      set_in(1, 0, DW'(v), 0, 1);
      step("t4f");
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, DW'(10 + i), 0, 1);
      step("t4");
      popped.push_back(b0.data_out);
      chk("t4.count", 32'(b0.fifo_count), 4);
      chk("t4.ovf", 32'(b0.overflow), 0);
    end
    foreach (exp_seq[i]) chk("t4.seq", 32'(popped[i]), 32'(exp_seq[i]));

    // 5: fall-through shows the word right after the write
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, '0, 0, 1);
      step("t5d");
    end
    set_in(1, 0, 6'd7, 0, 1);
    step("t5");
    chk("t5.ft_data", 32'(b1.data_out), 7);
    chk("t5.ft_valid", 32'(b1.valid_out), 1);
    set_in(0, 1, '0, 0, 1);
    step("t5r");
    chk("t5.ft_valid0", 32'(b1.valid_out), 0);
    chk("t5.ft_data0", 32'(b1.data_out), 0);

    // 6: read+write on empty, then reset mid-stream
    set_in(1, 1, 6'd9, 1, 1);
    step("t6");
    chk("t6.count", 32'(b0.fifo_count), 1);
    chk("t6.udf", 32'(b0.underflow), 1);
    for (int v = 0; v < 2; v++) begin
      set_in(1, 0, DW'(20 + v), 0, 1);
      step("t6w");
    end
    chk("t6.count3", 32'(b0.fifo_count), 3);
    set_in(1, 0, 6'd33, 0, 0);
    step("t6r");
    chk("t6.rst_count", 32'(b0.fifo_count), 0);
    chk("t6.rst_empty", 32'(b0.empty_fifo), 1);

    // Randomised traffic with occasional clears, resets and threshold changes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        th_hi = 3'($urandom_range(0, 4));
        th_lo = 3'($urandom_range(0, 4));
      end
      set_in(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
             DW'($urandom), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 99) != 0));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO for the PCIe transmit-layer data path. It replaces the fixed 6-bit, 4-entry FIFO with generic width and depth, and adds:
- programmable almost-full/almost-empty thresholds;
- an occupancy count output;
- a selectable first-word-fall-through (FWFT) read mode;
- sticky overflow/underflow flags with a clear input.

It sits between the lane-striping logic and the per-lane serialisers.

## Interface
- data_width, 6, width of each stored word
- address_width, 2, pointer width; DEPTH = 2**address_width entries
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through
- clk  in  1  single clock; every register updates on its rising edge
- reset  in  1  synchronous, active-low; sampled on posedge clk
- wr_enable  in  1  push data_in this cycle
- rd_enable  in  1  pop head word this cycle
- data_in  in  data_width  write data
- umbral_alto  in  address_width+1  almost-full threshold
- umbral_bajo  in  address_width+1  almost-empty threshold
- err_clear  in  1  synchronous clear of the sticky error flags
- data_out  out  data_width  read data
- valid_out  out  1  data_out carries a valid word
- fifo_count  out  address_width+1  occupancy, 0..DEPTH
- full_fifo, empty_fifo  out  1  each  occupancy == DEPTH / occupancy == 0
- almost_full_fifo  out  1  fifo_count >= umbral_alto
- almost_empty_fifo  out  1  fifo_count <= umbral_bajo
- overflow, underflow  out  1  each  sticky error flags
- error  out  1  overflow | underflow

## Operation
- **Storage.** DEPTH x data_width array with write pointer, read pointer and count registers. The pointers are address_width wide and wrap modulo DEPTH with no special case.
- **Reset.** Takes effect when reset == 0 at a posedge. It clears the pointers, count, data_out, valid_out, overflow and underflow. Resulting outputs:
  - empty_fifo = 1, full_fifo = 0, fifo_count = 0, error = 0;
  - almost_empty_fifo = 1;
  - almost_full_fifo = 1 only if umbral_alto == 0.
  - Array contents are not cleared.
  - A reset asserted mid-operation discards all stored words at that edge. Inputs sampled in the same cycle are ignored.
- **Accepted write.** wr_enable & (!full_fifo | (rd_enable & !empty_fifo)).
- **Accepted read.** rd_enable & !empty_fifo.
- **Count update.**
  - +1 on a write only, −1 on a read only.
  - Unchanged when both are accepted. Both being accepted while full is legal: the read frees the slot the write fills.
- **Empty with rd_enable & wr_enable.** The write is accepted, the read is rejected, and underflow sets.
- **Overflow.** Set when wr_enable & full_fifo & !rd_enable. The write is dropped and memory is untouched.
- **Underflow.** Set when rd_enable & empty_fifo. The pointers do not move.
- **Error clearing.** err_clear clears both sticky flags at the edge. If a new overflow or underflow event occurs in the same cycle, the event wins and the flag reads 1 after the edge.
- **FWFT = 0 (registered read).**
  - On an accepted read, data_out loads the head word and valid_out = 1 for the next cycle.
  - Otherwise valid_out = 0 and data_out holds its last value.
- **FWFT = 1 (fall-through).**
  - data_out = head word and valid_out = 1 combinationally while !empty_fifo.
  - When empty, data_out = 0 and valid_out = 0.
  - An accepted rd_enable consumes the displayed word.
- **Status flags.** All flags are combinational decodes of the registered count and the live threshold inputs. Changing a threshold changes its flag in the same cycle.

## Timing
- Write-to-visibility:
  - FWFT = 0: a word written at edge N can be popped by a read at edge N+1. It appears on data_out after edge N+1.
  - FWFT = 1: the word appears on data_out after edge N.
- fifo_count, full, empty and the almost flags update at the same edge as the accepted transfer. There is no extra pipeline stage.
- Sticky flags assert at the edge where the offending request is sampled.
- Full throughput is one write and one read per cycle, indefinitely, while 0 < count < DEPTH.

## Test plan
1. **Reset values.** Hold reset = 0 for 3 cycles, then release. Require:
   - fifo_count = 0, empty_fifo = 1, full_fifo = 0;
   - almost_empty_fifo = 1, error = 0, valid_out = 0, data_out = 0.
2. **Fill and overflow** (data_width = 6, address_width = 2, umbral_alto = 3, umbral_bajo = 1). Write 1, 2, 3, 4, 5 on consecutive cycles with rd_enable = 0. Require:
   - almost_full_fifo = 1 after the 3rd write;
   - full_fifo = 1 and count = 4 after the 4th write;
   - overflow = 1 after the 5th write, which is dropped.
3. **Drain, order and underflow.** From the full state, read 5 times (FWFT = 0). Require:
   - valid data_out 1, 2, 3, 4, one cycle after each read;
   - empty_fifo = 1, then underflow = 1 on the 5th read;
   - error = 1; err_clear for one cycle then returns error to 0.
4. **Simultaneous read/write with wrap.** With count = 4, hold rd_enable = wr_enable = 1 for 6 cycles, writing 10..15. Require:
   - count stays 4, overflow stays 0;
   - popped sequence 1, 2, 3, 4, 10, 11, confirming the pointers wrap correctly.
5. **FWFT mode** (FWFT = 1). Write 7 into the empty FIFO. Require:
   - data_out = 7 and valid_out = 1 the cycle after the write;
   - after one rd_enable, valid_out = 0 and data_out = 0.
6. **Empty with simultaneous read/write; reset mid-stream.**
   - On an empty FIFO with rd_enable = wr_enable = 1 and data_in = 9: require count = 1 and underflow = 1.
   - With 3 words stored, pulse reset = 0: require count = 0 and empty_fifo = 1 on the next cycle.
